// File: rtl/score_store_pkg.sv
// Shared types and constants for the score_store slice.
// Clamping of low scores is built only when SCORE_STORE_CLAMP_EN is defined.
package score_store_pkg;

   typedef logic signed [15:0] num;

   localparam num SCORE_FLOOR = -16'sd30000;
   localparam int SRAM_ADDR_W = 21;

   function automatic num clamp_score(input num value);
      return (value < SCORE_FLOOR) ? SCORE_FLOOR : value;
   endfunction

endpackage

// File: rtl/num_fifo.sv
// Show-ahead FIFO of signed scores; pop_data always presents the oldest entry.
// Pushes while full and pops while empty are ignored.
module num_fifo
   import score_store_pkg::*;
#(
   parameter int depth = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  num                         push_data,
   input  logic                       pop,
   output num                         pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(depth+1)-1:0] count
);

   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = $clog2(depth + 1);

   num               mem [depth];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so their difference is the fill level.
   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == CNT_W'(depth));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/score_store.sv
// Buffers one frame of senone scores and writes them to SRAM, then holds until send_done.
// Define SCORE_STORE_CLAMP_EN to floor incoming scores at SCORE_FLOOR before buffering.
module score_store
   import score_store_pkg::*;
#(
   parameter int                     n_senones  = 5,
   parameter int                     fifo_depth = 4,
   parameter logic [SRAM_ADDR_W-1:0] base_addr  = 21'h0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  num                     score,
   input  logic                   score_valid,
   output logic                   score_ready,
   output logic                   frame_done,
   input  logic                   send_done,
   output logic [SRAM_ADDR_W-1:0] data_addr,
   output num                     data_out,
   output logic                   write_data,
   input  logic                   sram_ready
);

   localparam int               CNT_W     = $clog2(n_senones + 1);
   localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(n_senones);

   localparam logic       F_FILL  = 1'b0;
   localparam logic       F_HOLD  = 1'b1;
   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_ISSUE = 2'd1;
   localparam logic [1:0] W_WAIT  = 2'd2;

   logic                              frame_state;
   logic [1:0]                        write_state;
   logic                              wait_blind;
   logic [CNT_W-1:0]                  accepted;
   logic [CNT_W-1:0]                  written;
   num                                push_data;
   num                                fifo_head;
   logic                              fifo_full;
   logic                              fifo_empty;
   logic [$clog2(fifo_depth+1)-1:0]   fifo_count;
   logic                              push;
   logic                              pop;
   logic                              frame_complete;
   logic                              frame_release;

   assign score_ready    = !fifo_full && (accepted < FRAME_LEN) && (frame_state == F_FILL);
   assign push           = score_valid && score_ready;
   assign pop            = (write_state == W_IDLE) && !fifo_empty && sram_ready;
   assign frame_complete = (frame_state == F_FILL) && (written == FRAME_LEN) && (fifo_count == '0);
   assign frame_release  = (frame_state == F_HOLD) && send_done;

`ifdef SCORE_STORE_CLAMP_EN
   assign push_data = clamp_score(score);
`else
   assign push_data = score;
`endif

   num_fifo #(
      .depth     (fifo_depth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Frame FSM enters HOLD in the same edge that raises frame_done, so the pulse cannot repeat.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_state <= F_FILL;
         frame_done  <= 1'b0;
         accepted    <= '0;
      end else begin
         frame_done <= frame_complete;
         if (frame_complete) begin
            frame_state <= F_HOLD;
         end else if (frame_release) begin
            frame_state <= F_FILL;
         end
         if (frame_release) begin
            accepted <= '0;
         end else if (push) begin
            accepted <= accepted + 1'b1;
         end
      end
   end

   // The strobe lands in the first W_WAIT cycle, before sram can drop ready, hence the blind cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         write_state <= W_IDLE;
         wait_blind  <= 1'b0;
         write_data  <= 1'b0;
         data_addr   <= base_addr;
         data_out    <= '0;
         written     <= '0;
      end else begin
         write_data <= 1'b0;
         case (write_state)
            W_IDLE: begin
               if (pop) begin
                  data_out    <= fifo_head;
                  data_addr   <= base_addr + (SRAM_ADDR_W'(written) << 1);
                  write_state <= W_ISSUE;
               end
            end
            W_ISSUE: begin
               write_data  <= 1'b1;
               wait_blind  <= 1'b1;
               write_state <= W_WAIT;
            end
            W_WAIT: begin
               if (wait_blind) begin
                  wait_blind <= 1'b0;
               end else if (sram_ready) begin
                  written     <= written + 1'b1;
                  write_state <= W_IDLE;
               end
            end
            default: write_state <= W_IDLE;
         endcase
         if (frame_release) written <= '0;
      end
   end

endmodule
